// File: rtl/obstacle_spawner_if.sv
// Game-side bundle for the obstacle spawner: frame tick, control, LFSR word,
// scroll speed, and the packed obstacle pool seen by renderer and collision.
//
// Strobe semantics: tick is a single-clk frame strobe with no back-pressure.
// An update happens in every cycle where tick && run && !clear. spawn_pulse
// and pass_cnt are single-clk results that appear one clk after that cycle.
interface obstacle_spawner_if #(
    parameter int NUM_SLOTS = 4,
    parameter int Y_W       = 10
);
    logic                     tick;
    logic                     run;
    logic                     clear;
    logic [15:0]              rnd;
    logic [2:0]               speed;
    logic [NUM_SLOTS-1:0]     obs_active;
    logic [2*NUM_SLOTS-1:0]   obs_lane;
    logic [Y_W*NUM_SLOTS-1:0] obs_y;
    logic                     spawn_pulse;
    logic [3:0]               pass_cnt;

    modport master (
        output tick, run, clear, rnd, speed,
        input  obs_active, obs_lane, obs_y, spawn_pulse, pass_cnt
    );

    modport slave (
        input  tick, run, clear, rnd, speed,
        output obs_active, obs_lane, obs_y, spawn_pulse, pass_cnt
    );
endinterface

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: a fixed pool of falling obstacles. Each frame update moves
// every live obstacle down by speed, retires those that leave the screen, then
// (when the randomised gap counter expires) tries to place a new obstacle into
// a random lane, provided a slot is free and the lane's top area is clear.
module obstacle_spawner #(
    parameter int NUM_SLOTS = 4,
    parameter int Y_W       = 10,
    parameter int SCREEN_H  = 480,
    parameter int OBS_H     = 32,
    parameter int MIN_GAP   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    obstacle_spawner_if.slave bus
);
    // Gap counter must hold MIN_GAP + 15 (up to 270).
    localparam int GAP_W = 9;
    localparam logic [Y_W:0]       Y_LIMIT   = (Y_W+1)'(SCREEN_H);
    localparam logic [Y_W-1:0]     Y_SPACING = Y_W'(2 * OBS_H);
    localparam logic [GAP_W-1:0]   GAP_BASE  = GAP_W'(MIN_GAP);

    logic [NUM_SLOTS-1:0] active_q;
    logic [1:0]           lane_q [NUM_SLOTS];
    logic [Y_W-1:0]       y_q    [NUM_SLOTS];
    logic [GAP_W-1:0]     gap_q;
    logic                 spawn_q;
    logic [3:0]           pass_q;

    logic [NUM_SLOTS-1:0] mv_active;
    logic [Y_W-1:0]       mv_y   [NUM_SLOTS];
    logic [Y_W:0]         sum    [NUM_SLOTS];
    logic [3:0]           retire_cnt;
    logic [GAP_W-1:0]     gap_dec;
    logic [GAP_W-1:0]     gap_next;
    logic                 attempt;
    logic [1:0]           pick_lane;
    logic                 blocked;
    logic                 found;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic                 accept;
    logic                 update;

    // Only the gap nibble and lane bits of the LFSR word are consumed.
    logic unused_rnd;
    assign unused_rnd = ^{bus.rnd[15:8], bus.rnd[3:2]};

    assign update = bus.tick && bus.run;

    // Next-frame computation: move/retire, gap countdown, lane pick and
    // spawn acceptance against the post-move pool.
    always_comb begin
        mv_active  = active_q;
        retire_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            sum[i]  = {1'b0, y_q[i]} + {{(Y_W-2){1'b0}}, bus.speed};
            mv_y[i] = y_q[i];
            if (active_q[i]) begin
                if (sum[i] >= Y_LIMIT) begin
                    mv_active[i] = 1'b0;
                    mv_y[i]      = '0;
                    retire_cnt   = retire_cnt + 4'd1;
                end else begin
                    mv_y[i] = sum[i][Y_W-1:0];
                end
            end
        end

        gap_dec  = gap_q - GAP_W'(1);
        attempt  = (gap_dec == '0);
        gap_next = attempt ? (GAP_BASE + GAP_W'(bus.rnd[7:4])) : gap_dec;

        // Only three lanes exist; the spare code folds into the middle lane.
        pick_lane = (bus.rnd[1:0] == 2'd3) ? 2'd1 : bus.rnd[1:0];

        blocked = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (mv_active[i] && (lane_q[i] == pick_lane) && (mv_y[i] < Y_SPACING)) begin
                blocked = 1'b1;
            end
        end

        found     = 1'b0;
        spawn_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && !mv_active[i]) begin
                spawn_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end

        accept = attempt && found && !blocked;
    end

    // Pool and counter registers; clear behaves like reset but synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lane_q[i] <= '0;
                y_q[i]    <= '0;
            end
            gap_q   <= GAP_BASE;
            spawn_q <= 1'b0;
            pass_q  <= '0;
        end else if (bus.clear) begin
            active_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lane_q[i] <= '0;
                y_q[i]    <= '0;
            end
            gap_q   <= GAP_BASE;
            spawn_q <= 1'b0;
            pass_q  <= '0;
        end else if (update) begin
            active_q <= mv_active | (accept ? spawn_sel : '0);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (accept && spawn_sel[i]) begin
                    lane_q[i] <= pick_lane;
                    y_q[i]    <= '0;
                end else begin
                    y_q[i] <= mv_y[i];
                end
            end
            gap_q   <= gap_next;
            spawn_q <= accept;
            pass_q  <= retire_cnt;
        end else begin
            spawn_q <= 1'b0;
            pass_q  <= '0;
        end
    end

    // Pack the pool into the flat output buses.
    always_comb begin
        bus.obs_active  = active_q;
        bus.obs_lane    = '0;
        bus.obs_y       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bus.obs_lane[2*i +: 2]   = lane_q[i];
            bus.obs_y[Y_W*i +: Y_W]  = y_q[i];
        end
        bus.spawn_pulse = spawn_q;
        bus.pass_cnt    = pass_q;
    end
endmodule
